// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the serial pair serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_cmp_pkg;

  // IDLE: no word held; SHIFT: a word pair is being emitted bit by bit.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register for one operand.
// Latency: a loaded word shows its first bit on ser_out in the cycle after load.
// Backpressure: shifts only when shift_en is high; load overrides shift.
//
// Ports: clk, rst (sync, active-high), load + load_dat (parallel load),
//        shift_en (advance one bit), ser_out (current serial bit).
module piso_shift
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_dat,
  input  logic             shift_en,
  output logic             ser_out
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Shifting in zeros means the register is empty once a word has drained.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_dat;
    end else if (shift_en) begin
      if (MSB_FIRST) sr_d = sr_q << 1;
      else           sr_d = sr_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign ser_out = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/serial_pair_serializer.sv
// Serializes a pair of WIDTH-bit words into lock-stepped bit pairs with first/last markers.
// Latency: first bit appears the cycle after input transfer; back-to-back words have no bubble.
// Backpressure: out_ready=0 freezes the current bit; in_ready only when idle or on the last bit transfer.
//
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_a/in_b (word pair input);
//        out_valid/out_ready/out_a/out_b/out_first/out_last (serial bit pair output).
module serial_pair_serializer
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_a,
  output logic             out_b,
  output logic             out_first,
  output logic             out_last
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_xfer;
  logic            out_xfer;
  logic            shift_en;
  logic            ser_a;
  logic            ser_b;

  assign out_valid = (state_q == SHIFT);
  assign out_first = out_valid && (cnt_q == '0);
  assign out_last  = out_valid && (cnt_q == LAST_CNT);
  assign out_xfer  = out_valid && out_ready;

  // Accepting on the last bit transfer is what removes the bubble between words.
  assign in_ready  = !rst && ((state_q == IDLE) || (out_xfer && out_last));
  assign in_xfer   = in_valid && in_ready;
  assign shift_en  = out_xfer && !in_xfer;

  // Register contents drain to zero, but gating keeps idle outputs at 0 unconditionally.
  assign out_a = out_valid && ser_a;
  assign out_b = out_valid && ser_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (in_xfer) begin
      state_d = SHIFT;
      cnt_d   = '0;
    end else if (out_xfer) begin
      if (out_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  piso_shift #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_piso_a (
    .clk      (clk),
    .rst      (rst),
    .load     (in_xfer),
    .load_dat (in_a),
    .shift_en (shift_en),
    .ser_out  (ser_a)
  );

  piso_shift #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_piso_b (
    .clk      (clk),
    .rst      (rst),
    .load     (in_xfer),
    .load_dat (in_b),
    .shift_en (shift_en),
    .ser_out  (ser_b)
  );

endmodule
